// File: rtl/smi_mem_lib_write_burst_test_gen64.sv
// smi_mem_lib_write_burst_test_gen64: issues one write burst per test descriptor, streams a
// 64-bit counting sequence as write data, and reports the write status with an elapsed-cycle count.
module smi_mem_lib_write_burst_test_gen64 #(
    parameter int CYCLE_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         testParamsValid,
    input  logic [63:0]                  testParamBurstAddr,
    input  logic [31:0]                  testParamBurstLen,
    input  logic [7:0]                   testParamBurstOpts,
    input  logic [63:0]                  testParamDataInit,
    input  logic [63:0]                  testParamDataIncr,
    output logic                         testParamsStop,
    output logic                         testDoneValid,
    output logic                         testDoneStatusOk,
    output logic [CYCLE_COUNT_WIDTH-1:0] testDoneCycles,
    input  logic                         testDoneStop,
    output logic                         writeParamsValid,
    output logic [63:0]                  writeParamBurstAddr,
    output logic [31:0]                  writeParamBurstLen,
    output logic [7:0]                   writeParamBurstOpts,
    input  logic                         writeParamsStop,
    output logic                         writeDataValid,
    output logic [63:0]                  writeDataValue,
    input  logic                         writeDataStop,
    input  logic                         writeDoneValid,
    input  logic                         writeDoneStatusOk,
    output logic                         writeDoneStop
);
    typedef enum logic [2:0] {IDLE, SET_PARAMS, WRITE_DATA, GET_STATUS, REPORT} state_t;

    state_t                       r_state;
    logic [63:0]                  r_addr;
    logic [31:0]                  r_len;
    logic [7:0]                   r_opts;
    logic [63:0]                  r_data;
    logic [63:0]                  r_incr;
    logic [31:0]                  r_beats;
    logic [CYCLE_COUNT_WIDTH-1:0] r_cycles;
    logic                         r_status;
    logic                         r_params_stop;
    logic                         r_wp_valid;
    logic                         r_wd_valid;
    logic                         r_wdone_stop;
    logic                         r_td_valid;

    logic                         w_params_xfer;
    logic                         w_wp_xfer;
    logic                         w_wd_xfer;
    logic                         w_td_xfer;
    logic [CYCLE_COUNT_WIDTH-1:0] w_cycles_inc;

    assign w_params_xfer = testParamsValid & ~r_params_stop;
    assign w_wp_xfer     = r_wp_valid & ~writeParamsStop;
    assign w_wd_xfer     = r_wd_valid & ~writeDataStop;
    assign w_td_xfer     = r_td_valid & ~testDoneStop;
    // Saturating so a stalled controller can never wrap the reported count.
    assign w_cycles_inc  = (&r_cycles) ? r_cycles : r_cycles + CYCLE_COUNT_WIDTH'(1);

    assign testParamsStop      = r_params_stop;
    assign testDoneValid       = r_td_valid;
    assign testDoneStatusOk    = r_status;
    assign testDoneCycles      = r_cycles;
    assign writeParamsValid    = r_wp_valid;
    assign writeParamBurstAddr = r_addr;
    assign writeParamBurstLen  = r_len;
    assign writeParamBurstOpts = r_opts;
    assign writeDataValid      = r_wd_valid;
    assign writeDataValue      = r_data;
    assign writeDoneStop       = r_wdone_stop;

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_opts        <= '0;
            r_data        <= '0;
            r_incr        <= '0;
            r_beats       <= '0;
            r_cycles      <= '0;
            r_status      <= 1'b0;
            r_params_stop <= 1'b1;
            r_wp_valid    <= 1'b0;
            r_wd_valid    <= 1'b0;
            r_wdone_stop  <= 1'b1;
            r_td_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_params_stop <= 1'b0;
                    if (w_params_xfer) begin
                        r_addr        <= testParamBurstAddr;
                        r_len         <= testParamBurstLen;
                        r_opts        <= testParamBurstOpts;
                        r_data        <= testParamDataInit;
                        r_incr        <= testParamDataIncr;
                        r_beats       <= testParamBurstLen;
                        r_cycles      <= '0;
                        r_params_stop <= 1'b1;
                        if (testParamBurstLen != 32'd0) begin
                            r_state    <= SET_PARAMS;
                            r_wp_valid <= 1'b1;
                        end else begin
                            r_state    <= REPORT;
                            r_status   <= 1'b1;
                            r_cycles   <= CYCLE_COUNT_WIDTH'(1);
                            r_td_valid <= 1'b1;
                        end
                    end
                end
                SET_PARAMS: begin
                    r_cycles <= w_cycles_inc;
                    if (w_wp_xfer) begin
                        r_state    <= WRITE_DATA;
                        r_wp_valid <= 1'b0;
                        r_wd_valid <= 1'b1;
                    end
                end
                WRITE_DATA: begin
                    r_cycles <= w_cycles_inc;
                    if (w_wd_xfer) begin
                        r_data  <= r_data + r_incr;
                        r_beats <= r_beats - 32'd1;
                        if (r_beats == 32'd1) begin
                            r_state      <= GET_STATUS;
                            r_wd_valid   <= 1'b0;
                            r_wdone_stop <= 1'b0;
                        end
                    end
                end
                GET_STATUS: begin
                    r_cycles <= w_cycles_inc;
                    if (writeDoneValid) begin
                        r_state      <= REPORT;
                        r_status     <= writeDoneStatusOk;
                        r_wdone_stop <= 1'b1;
                        r_td_valid   <= 1'b1;
                    end
                end
                REPORT: begin
                    if (w_td_xfer) begin
                        r_state    <= IDLE;
                        r_td_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smi_mem_lib_write_burst_test_gen64.sv
// tb_smi_mem_lib_write_burst_test_gen64: directed tests with a scoreboard of expected
// write requests, data beats and test-done reports, compared at each observed transfer.
module tb_smi_mem_lib_write_burst_test_gen64;
    localparam int CW = 32;

    typedef struct {logic [63:0] a; logic [31:0] l; logic [7:0] o;} wp_t;
    typedef struct {logic ok; logic [CW-1:0] cyc;} td_t;

    logic          clk = 1'b0;
    logic          srst = 1'b0;
    logic          testParamsValid = 1'b0;
    logic [63:0]   testParamBurstAddr = '0;
    logic [31:0]   testParamBurstLen = '0;
    logic [7:0]    testParamBurstOpts = '0;
    logic [63:0]   testParamDataInit = '0;
    logic [63:0]   testParamDataIncr = '0;
    logic          testParamsStop;
    logic          testDoneValid;
    logic          testDoneStatusOk;
    logic [CW-1:0] testDoneCycles;
    logic          testDoneStop = 1'b0;
    logic          writeParamsValid;
    logic [63:0]   writeParamBurstAddr;
    logic [31:0]   writeParamBurstLen;
    logic [7:0]    writeParamBurstOpts;
    logic          writeParamsStop = 1'b0;
    logic          writeDataValid;
    logic [63:0]   writeDataValue;
    logic          writeDataStop = 1'b0;
    logic          writeDoneValid = 1'b0;
    logic          writeDoneStatusOk = 1'b0;
    logic          writeDoneStop;

    int total = 0;
    int bad = 0;

    logic [63:0] q_data[$];
    wp_t         q_wp[$];
    td_t         q_td[$];

    int   ncyc = 0;
    int   beats_cnt = 0;
    int   wpv_cnt = 0;
    int   wdv_cnt = 0;
    int   td_seen = 0;
    int   last_beat = -10;
    int   streak = 0;
    logic held = 1'b0;
    logic [63:0] held_val = '0;

    always #5 clk = ~clk;

    smi_mem_lib_write_burst_test_gen64 #(.CYCLE_COUNT_WIDTH(CW)) dut (
        .clk(clk), .srst(srst),
        .testParamsValid(testParamsValid), .testParamBurstAddr(testParamBurstAddr),
        .testParamBurstLen(testParamBurstLen), .testParamBurstOpts(testParamBurstOpts),
        .testParamDataInit(testParamDataInit), .testParamDataIncr(testParamDataIncr),
        .testParamsStop(testParamsStop),
        .testDoneValid(testDoneValid), .testDoneStatusOk(testDoneStatusOk),
        .testDoneCycles(testDoneCycles), .testDoneStop(testDoneStop),
        .writeParamsValid(writeParamsValid), .writeParamBurstAddr(writeParamBurstAddr),
        .writeParamBurstLen(writeParamBurstLen), .writeParamBurstOpts(writeParamBurstOpts),
        .writeParamsStop(writeParamsStop),
        .writeDataValid(writeDataValid), .writeDataValue(writeDataValue),
        .writeDataStop(writeDataStop),
        .writeDoneValid(writeDoneValid), .writeDoneStatusOk(writeDoneStatusOk),
        .writeDoneStop(writeDoneStop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_present(input string tag, input int size);
        total++;
        assert (size > 0) else begin
            bad++;
            $error("FAIL %s observed=transfer expected=none", tag);
        end
    endtask

    // Transfers complete at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        ncyc++;
        if (writeParamsValid) wpv_cnt++;
        if (writeParamsValid && !writeParamsStop) begin
            chk_present("wp_extra", q_wp.size());
            if (q_wp.size() > 0) begin
                wp_t e;
                e = q_wp.pop_front();
                chk("wp_addr", writeParamBurstAddr, e.a);
                chk("wp_len", 64'(writeParamBurstLen), 64'(e.l));
                chk("wp_opts", 64'(writeParamBurstOpts), 64'(e.o));
            end
        end
        if (writeDataValid) begin
            wdv_cnt++;
            if (held) chk("wd_stable", writeDataValue, held_val);
            if (writeDataStop) begin
                held = 1'b1;
                held_val = writeDataValue;
            end else begin
                held = 1'b0;
                beats_cnt++;
                streak = (last_beat == ncyc - 1) ? streak + 1 : 1;
                last_beat = ncyc;
                chk_present("wd_extra", q_data.size());
                if (q_data.size() > 0) chk("wd_value", writeDataValue, q_data.pop_front());
            end
        end else begin
            held = 1'b0;
        end
        if (testDoneValid && !testDoneStop) begin
            td_seen++;
            chk_present("td_extra", q_td.size());
            if (q_td.size() > 0) begin
                td_t e;
                e = q_td.pop_front();
                chk("td_ok", 64'(testDoneStatusOk), 64'(e.ok));
                chk("td_cycles", 64'(testDoneCycles), 64'(e.cyc));
            end
        end
    end

    task automatic send_desc(input logic [63:0] a, input logic [31:0] len, input logic [63:0] init,
                             input logic [63:0] incr, input logic [7:0] opts);
        logic [63:0] d;
        int n;
        d = init;
        n = 0;
        if (len != 0) q_wp.push_back('{a, len, opts});
        for (int i = 0; i < int'(len); i++) begin
            q_data.push_back(d);
            d = d + incr;
        end
        testParamsValid = 1'b1;
        testParamBurstAddr = a;
        testParamBurstLen = len;
        testParamBurstOpts = opts;
        testParamDataInit = init;
        testParamDataIncr = incr;
        while (testParamsStop && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("desc_ready", 64'(testParamsStop), 64'd0);
        @(posedge clk); #1;
        testParamsValid = 1'b0;
    endtask

    // exp_cyc < 0 takes the cycle count measured at the ports (used when stalling).
    task automatic run_test(input logic [63:0] a, input logic [31:0] len, input logic [63:0] init,
                            input logic [63:0] incr, input logic [7:0] opts, input bit stall,
                            input logic st, input int hold, input int exp_cyc);
        int k;
        int n;
        int td0;
        logic s;
        logic [CW-1:0] c;
        k = 0;
        n = 0;
        td0 = td_seen;
        writeDataStop = stall;
        writeDoneValid = (len != 0);
        writeDoneStatusOk = st;
        testDoneStop = (hold > 0);
        send_desc(a, len, init, incr, opts);
        if (len == 0) begin
            c = CW'(1);
            chk("zero_done_next", 64'(testDoneValid), 64'd1);
        end else begin
            while (k < 200) begin
                s = writeDoneStop;
                @(posedge clk); #1;
                k++;
                if (stall) writeDataStop = ~writeDataStop;
                if (!s) break;
            end
            writeDoneValid = 1'b0;
            writeDataStop = 1'b0;
            if (exp_cyc >= 0) chk("cycles_meas", 64'(k), 64'(exp_cyc));
            c = (exp_cyc >= 0) ? CW'(exp_cyc) : CW'(k);
        end
        q_td.push_back('{st, c});
        repeat (hold) begin
            chk("td_held", 64'(testDoneValid), 64'd1);
            chk("td_hold_ok", 64'(testDoneStatusOk), 64'(st));
            chk("td_hold_cyc", 64'(testDoneCycles), 64'(c));
            chk("desc_blocked", 64'(testParamsStop), 64'd1);
            @(posedge clk); #1;
        end
        testDoneStop = 1'b0;
        while (td_seen == td0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("td_count", 64'(td_seen - td0), 64'd1);
    endtask

    initial begin
        int wp0;
        int wd0;
        int td0;
        int n;
        #12;
        chk("rst_pstop", 64'(testParamsStop), 64'd1);
        chk("rst_tdv", 64'(testDoneValid), 64'd0);
        chk("rst_ok", 64'(testDoneStatusOk), 64'd0);
        chk("rst_cyc", 64'(testDoneCycles), 64'd0);
        chk("rst_wpv", 64'(writeParamsValid), 64'd0);
        chk("rst_wdv", 64'(writeDataValid), 64'd0);
        chk("rst_wdstop", 64'(writeDoneStop), 64'd1);
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_pstop", 64'(testParamsStop), 64'd0);

        run_test(64'h1000, 32'd4, 64'h10, 64'h8, 8'hA5, 1'b0, 1'b1, 0, 6);
        chk("no_bubble_4", 64'(streak), 64'd4);

        run_test(64'h1000, 32'd4, 64'h10, 64'h8, 8'hA5, 1'b1, 1'b1, 0, -1);

        run_test(64'h2000, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 8'h00, 1'b0, 1'b1, 0, 5);
        chk("no_bubble_3", 64'(streak), 64'd3);

        wp0 = wpv_cnt;
        wd0 = wdv_cnt;
        run_test(64'h3000, 32'd0, 64'h5, 64'h1, 8'h11, 1'b0, 1'b1, 0, 1);
        chk("zero_no_wpv", 64'(wpv_cnt - wp0), 64'd0);
        chk("zero_no_wdv", 64'(wdv_cnt - wd0), 64'd0);

        run_test(64'h4000, 32'd2, 64'h7, 64'h1, 8'h03, 1'b0, 1'b0, 5, 4);

        wd0 = beats_cnt;
        td0 = td_seen;
        n = 0;
        send_desc(64'h8000, 32'd8, 64'h0, 64'h1, 8'h00);
        while (beats_cnt < wd0 + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_beats", 64'(beats_cnt - wd0), 64'd2);
        chk("rst_mid_wdv_pre", 64'(writeDataValid), 64'd1);
        #2;
        srst = 1'b0;
        #1;
        chk("rst_async_wdv", 64'(writeDataValid), 64'd0);
        chk("rst_async_pstop", 64'(testParamsStop), 64'd1);
        q_data.delete();
        repeat (3) @(posedge clk);
        #2;
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_release_pstop", 64'(testParamsStop), 64'd0);
        chk("rst_release_wdv", 64'(writeDataValid), 64'd0);
        chk("rst_no_done", 64'(td_seen - td0), 64'd0);

        run_test(64'h5000, 32'd2, 64'h100, 64'h10, 8'h42, 1'b0, 1'b1, 0, 4);
        chk("no_bubble_2", 64'(streak), 64'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("q_data_empty", 64'(q_data.size()), 64'd0);
        chk("q_wp_empty", 64'(q_wp.size()), 64'd0);
        chk("q_td_empty", 64'(q_td.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/smi_mem_lib_write_burst_test_gen64.md
Name: smi_mem_lib_write_burst_test_gen64

Overview:
- Memory access library write burst test generator; the stage upstream of the read burst test checker.
- Accepts a test descriptor, issues one write burst request, and streams a 64-bit counting sequence (init, init+incr, ...) as write data.
- Forwards the write controller's completion status, together with a cycle count, as test done.
- The read checker is then run with the same descriptor to verify the memory contents.

Parameters:
- CYCLE_COUNT_WIDTH, 32, width of the elapsed-cycle counter reported at test done.

Ports:
- clk  in  1  system clock
- srst  in  1  reset, asynchronous assert, active-low
- testParamsValid  in  1  test descriptor valid
- testParamBurstAddr  in  64  burst start byte address
- testParamBurstLen  in  32  burst length in 64-bit beats
- testParamBurstOpts  in  8  burst options, passed through
- testParamDataInit  in  64  first data word
- testParamDataIncr  in  64  per-beat data increment
- testParamsStop  out  1  descriptor backpressure
- testDoneValid  out  1  test complete
- testDoneStatusOk  out  1  write controller reported success
- testDoneCycles  out  CYCLE_COUNT_WIDTH  cycles taken by the test
- testDoneStop  in  1  done backpressure
- writeParamsValid  out  1  burst request valid
- writeParamBurstAddr  out  64  registered address
- writeParamBurstLen  out  32  registered length
- writeParamBurstOpts  out  8  registered options
- writeParamsStop  in  1  burst request backpressure
- writeDataValid  out  1  data beat valid
- writeDataValue  out  64  data beat value
- writeDataStop  in  1  data backpressure
- writeDoneValid  in  1  write controller done
- writeDoneStatusOk  in  1  write controller status
- writeDoneStop  out  1  done backpressure toward write controller

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low. While srst=0, state is Idle and all registers clear.
  - Outputs during reset: all valids 0, all stops 1, testDoneStatusOk 0, testDoneCycles 0.
  - After srst deasserts, the block starts in Idle.
- Handshakes: every interface is valid/stop. A transfer occurs on a rising edge where valid=1 and stop=0. A valid, once asserted, stays asserted with stable payload until it transfers.
- State machine: Idle, SetParams, WriteData, GetStatus, Report.
- Idle:
  - testParamsStop=0; all other valids 0; writeDoneStop=1.
  - On descriptor transfer: register addr, len, opts, init, incr; set beat counter = len; clear cycle counter.
  - len != 0 -> SetParams. len == 0 -> Report with statusOk=1 and cycles=1. No write request is issued for a zero-length burst.
- SetParams:
  - writeParamsValid=1, payload from registers.
  - Transfer -> WriteData.
- WriteData:
  - writeDataValid=1; writeDataValue = data register.
  - On each beat transfer: data += incr (modulo 2^64, wraps silently); beat counter -= 1.
  - Transfer while beat counter == 1 -> GetStatus.
  - No bubbles: writeDataValid stays 1 on consecutive cycles while writeDataStop=0.
- GetStatus:
  - writeDoneStop=0.
  - On writeDoneValid=1: latch writeDoneStatusOk -> Report.
  - The write controller's done is consumed here, never combinationally forwarded.
- Report:
  - testDoneValid=1; testDoneStatusOk = latched status; testDoneCycles = latched count.
  - Transfer -> Idle.
- Cycle counter:
  - Increments on every clock edge in SetParams, WriteData and GetStatus.
  - Saturates at all-ones; no wrap.
  - The value at GetStatus exit, plus 1, is latched for Report.
  - Minimum value for len=1 with no stalls is 3: SetParams 1, WriteData 1, GetStatus 1.
- Pass-through of descriptor fields: writeParamBurstLen and Opts pass unmodified. The block performs no address alignment checks.
- Simultaneous events:
  - testParamsValid during non-Idle states is held off (testParamsStop=1).
  - writeDoneValid arriving before GetStatus is held off (writeDoneStop=1).
- Reset mid-operation:
  - Immediate return to Idle; any in-flight burst is abandoned.
  - No done is emitted for the abandoned burst.

Test Plan:
- Descriptor addr=0x1000, len=4, init=0x10, incr=0x8, no stalls:
  - one write request with addr 0x1000, len 4;
  - data 0x10, 0x18, 0x20, 0x28 on 4 consecutive cycles;
  - writeDone ok=1 -> testDone ok=1, cycles=6.
- Same descriptor with writeDataStop toggled every other cycle:
  - identical data sequence, no duplicate or dropped beats;
  - payload stable while stopped.
- Wrap-around: init=0xFFFFFFFFFFFFFFFF, incr=2, len=3 -> data 0xFFFFFFFFFFFFFFFF, 0x1, 0x3.
- len=0:
  - no writeParamsValid and no writeDataValid ever asserted;
  - testDoneValid one cycle after the descriptor transfer, ok=1, cycles=1.
- writeDoneStatusOk=0 with testDoneStop held high 5 cycles:
  - testDoneValid held, ok=0, count stable;
  - the next descriptor is accepted only after the done transfer.
- srst pulled low mid-WriteData after 2 of 8 beats:
  - writeDataValid drops asynchronously;
  - after release, Idle with testParamsStop=0;
  - a new len=2 test completes correctly.
